// File: rtl/chip8_seq_alu.sv
// Handshaked Chip8 ALU: single-cycle logic/arith ops, bit-serial shifts and an
// 8-step double-dabble BCD conversion, result held in DONE until consumed.
package chip8_alu_pkg;
  typedef enum logic [3:0] {
    ALU_f_NOP, ALU_f_OR, ALU_f_AND, ALU_f_XOR, ALU_f_ADD, ALU_f_MINUS,
    ALU_f_EQUALS, ALU_f_GREATER, ALU_f_INC, ALU_f_LSHIFT, ALU_f_RSHIFT, ALU_f_BCD
  } ALU_f;
endpackage

module chip8_seq_alu
  import chip8_alu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FLAG_BIT = 8,
  parameter int SHAMT_W  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  ALU_f             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             alu_carry,
  output logic             busy
);
  localparam int CNT_W = (SHAMT_W > 4) ? SHAMT_W : 4;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_BCD, S_DONE} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0] r_acc, r_out;
  logic             r_left, r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [19:0]      r_dd;     // {hundreds, tens, ones, binary byte}

  logic               w_accept, w_last, w_simple_c;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_simple_out, w_shift_next, w_bcd_out;
  logic [19:0]        w_dd_adj, w_dd_next;

  assign w_accept     = in_valid && in_ready;
  assign w_shamt      = input2[SHAMT_W-1:0];
  assign w_last       = (r_cnt == CNT_W'(1));
  assign w_sum        = {1'b0, input1} + {1'b0, input2};
  assign w_shift_next = r_left ? (r_acc << 1) : (r_acc >> 1);

  always_comb begin
    w_simple_out = '0;
    w_simple_c   = 1'b0;
    case (sel)
      ALU_f_OR:      w_simple_out = input1 | input2;
      ALU_f_AND:     w_simple_out = input1 & input2;
      ALU_f_XOR:     w_simple_out = input1 ^ input2;
      ALU_f_ADD: begin
        w_simple_out = w_sum[WIDTH-1:0];
        w_simple_c   = |w_sum[WIDTH:FLAG_BIT];
      end
      ALU_f_MINUS: begin
        w_simple_out = input1 - input2;
        w_simple_c   = (input2 > input1);
      end
      ALU_f_EQUALS:  w_simple_out[0] = (input1 == input2);
      ALU_f_GREATER: w_simple_out[0] = (input1 > input2);
      ALU_f_INC:     w_simple_out = input1 + WIDTH'(1);
      // zero shift amount bypasses the SHIFT state
      ALU_f_LSHIFT, ALU_f_RSHIFT: w_simple_out = input1;
      default: ;
    endcase
  end

  // Add-3 on any BCD digit >= 5, then shift the whole scratch left one bit
  always_comb begin
    w_dd_adj = r_dd;
    for (int i = 0; i < 3; i++)
      if (r_dd[8+4*i +: 4] >= 4'd5) w_dd_adj[8+4*i +: 4] = r_dd[8+4*i +: 4] + 4'd3;
  end
  assign w_dd_next = w_dd_adj << 1;

  always_comb begin
    w_bcd_out = '0;
    for (int i = 0; i < 12; i++)
      if (i < WIDTH) w_bcd_out[i] = w_dd_next[8+i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (w_accept) begin
          if (sel == ALU_f_BCD) w_next = S_BCD;
          else if ((sel == ALU_f_LSHIFT || sel == ALU_f_RSHIFT) && w_shamt != '0)
            w_next = S_SHIFT;
          else w_next = S_DONE;
        end
      end
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_BCD:   if (w_last) w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_out   <= '0;
      r_left  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_dd    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_acc  <= input1;
          r_left <= (sel == ALU_f_LSHIFT);
          r_dd   <= {12'd0, input1[7:0]};
          r_cnt  <= (sel == ALU_f_BCD) ? CNT_W'(8) : CNT_W'(w_shamt);
          if (w_next == S_DONE) begin
            r_out   <= w_simple_out;
            r_carry <= w_simple_c;
          end
        end
        S_SHIFT: begin
          r_acc <= w_shift_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_out   <= w_shift_next;
            r_carry <= 1'b0;
          end
        end
        S_BCD: begin
          r_dd  <= w_dd_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_out   <= w_bcd_out;
            r_carry <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out       = r_out;
  assign alu_carry = r_carry;
endmodule

// File: tb/tb_chip8_seq_alu.sv
// Self-checking bench for chip8_seq_alu: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_chip8_seq_alu;
  import chip8_alu_pkg::*;

  logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] input1 = '0, input2 = '0;
  ALU_f        sel = ALU_f_NOP;
  logic        in_ready, out_valid, alu_carry, busy;
  logic [15:0] out;
  int errors = 0, checks = 0;

  chip8_seq_alu #(.WIDTH(16), .FLAG_BIT(8), .SHAMT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .input1(input1), .input2(input2), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .alu_carry(alu_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model(input ALU_f op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output int lat);
    int unsigned s, n, v;
    r = 16'h0; c = 1'b0; lat = 1;
    n = b % 16;
    case (op)
      ALU_f_OR:      r = a | b;
      ALU_f_AND:     r = a & b;
      ALU_f_XOR:     r = a ^ b;
      ALU_f_ADD:     begin s = a + b; r = s[15:0]; c = (s >= 256); end
      ALU_f_MINUS:   begin r = a - b; c = (b > a); end
      ALU_f_EQUALS:  r = (a == b) ? 16'd1 : 16'd0;
      ALU_f_GREATER: r = (a > b) ? 16'd1 : 16'd0;
      ALU_f_INC:     r = a + 16'd1;
      ALU_f_LSHIFT:  begin r = a << n; lat = n + 1; end
      ALU_f_RSHIFT:  begin r = a >> n; lat = n + 1; end
      ALU_f_BCD: begin
        v = a % 256;
        s = (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
        r = s[15:0]; lat = 9;
      end
      default: ;
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, report result and latency
  task automatic run_op(input ALU_f op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic c, output int lat);
    @(negedge clk);
    input1 = a; input2 = b; sel = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0; input1 = 16'($urandom); input2 = 16'($urandom);
      sel = ALU_f'($urandom_range(0, 15));
      lat++;
    end while (!out_valid && lat < 40);
    r = out; c = alu_carry;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; sel = ALU_f_OR; input1 = 16'hF5A0; input2 = 16'hFA50;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out !== 16'h0) begin errors++; $display("FAIL reset_out got=%h want=0000", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    in_valid = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_directed();
    ALU_f        ops [9] = '{ALU_f_OR, ALU_f_ADD, ALU_f_ADD, ALU_f_MINUS, ALU_f_MINUS,
                             ALU_f_LSHIFT, ALU_f_RSHIFT, ALU_f_RSHIFT, ALU_f_BCD};
    logic [15:0] as  [9] = '{16'hF5A0, 16'd180, 16'd5, 16'h7003, 16'hC3C3,
                             16'h0031, 16'h1111, 16'h1111, 16'h00FF};
    logic [15:0] bs  [9] = '{16'hFA50, 16'd180, 16'd5, 16'hE0A5, 16'hC3C3,
                             16'd2, 16'd0, 16'd15, 16'h0000};
    logic [15:0] er  [9] = '{16'hFFF0, 16'd360, 16'd10, 16'd36702, 16'h0000,
                             16'h00C4, 16'h1111, 16'h0000, 16'h0255};
    logic        ec  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          el  [9] = '{1, 1, 1, 1, 1, 3, 1, 16, 9};
    logic [15:0] r; logic c; int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], r, c, lat);
      checks++; if (r !== er[i]) begin errors++; $display("FAIL dir%0d_out got=%h want=%h", i, r, er[i]); end
      checks++; if (c !== ec[i]) begin errors++; $display("FAIL dir%0d_carry got=%b want=%b", i, c, ec[i]); end
      checks++; if (lat != el[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, el[i]); end
    end
  endtask

  task automatic test_bcd_zero();
    logic [15:0] r; logic c; int lat;
    run_op(ALU_f_BCD, 16'hAB00, 16'h1234, r, c, lat);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL bcd_zero_out got=%h want=0000", r); end
    checks++; if (lat != 9) begin errors++; $display("FAIL bcd_zero_latency got=%0d want=9", lat); end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r, mr; logic c, mc; int lat, ml; ALU_f op;
    for (int i = 0; i < 150; i++) begin
      op = ALU_f'($urandom_range(0, 15));
      a  = 16'($urandom); b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {8'h00, a[7:0]};
      model(op, a, b, mr, mc, ml);
      run_op(op, a, b, r, c, lat);
      checks++; if (r !== mr) begin errors++; $display("FAIL rand%0d_out op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, r, mr); end
      checks++; if (c !== mc) begin errors++; $display("FAIL rand%0d_carry op=%0d a=%h b=%h got=%b want=%b", i, op, a, b, c, mc); end
      checks++; if (lat != ml) begin errors++; $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", i, op, lat, ml); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    input1 = 16'd8; input2 = 16'd8; sel = ALU_f_EQUALS; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    input1 = 16'h00FF; sel = ALU_f_BCD;  // held request must not be taken while busy
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out !== 16'd1 || alu_carry !== 1'b0)
        begin errors++; $display("FAIL bp%0d_hold got valid=%b out=%h c=%b want 1/0001/0", k, out_valid, out, alu_carry); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1)
        begin errors++; $display("FAIL bp%0d_status got in_ready=%b busy=%b want 0/1", k, in_ready, busy); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 16'd1)
      begin errors++; $display("FAIL bp_handoff got valid=%b in_ready=%b out=%h want 0/1/0001", out_valid, in_ready, out); end
    in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] r; logic c; int lat;
    @(negedge clk);
    input1 = 16'h0099; sel = ALU_f_BCD; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (out !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || alu_carry !== 1'b0)
      begin errors++; $display("FAIL mid_reset got out=%h valid=%b busy=%b in_ready=%b c=%b", out, out_valid, busy, in_ready, alu_carry); end
    repeat (12) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid got=%b want=0", out_valid); end
    end
    reset_n = 1'b1;
    run_op(ALU_f_INC, 16'hFFFF, 16'h0000, r, c, lat);
    checks++; if (r !== 16'h0000 || c !== 1'b0 || lat != 1)
      begin errors++; $display("FAIL mid_inc got out=%h c=%b lat=%0d want 0000/0/1", r, c, lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bcd_zero();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
